// File: rtl/ch_est_freq_interp.sv
`default_nettype none
// ch_est_freq_interp: captures four NRS pilot estimates for one PRB and streams
// 12 linearly interpolated subcarrier estimates over valid/ready.  Rev 1.0
module ch_est_freq_interp #(
  parameter int WIDTH_EST = 17,
  parameter int DIV3_MUL  = 21846
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  nrs_shift,
  input  logic [4*WIDTH_EST-1:0]      e_re,
  input  logic [4*WIDTH_EST-1:0]      e_im,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_EST-1:0] h_re,
  output logic signed [WIDTH_EST-1:0] h_im,
  output logic [3:0]                  sc_idx,
  output logic                        last,
  output logic                        busy
);

  localparam int c_pw = WIDTH_EST + 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [4*WIDTH_EST-1:0]      e_re_q, e_im_q;
  logic [1:0]                  p0_q;
  logic [3:0]                  n_q, n_d;
  logic                        valid_q, valid_d;
  logic signed [WIDTH_EST-1:0] h_re_q, h_im_q;
  logic [3:0]                  sc_q;
  logic                        last_q;
  logic                        capture;
  logic                        load;

  // Linear interpolation between neighbouring pilots; m/3 is realised as
  // m*DIV3_MUL in Q16 with round-half-up, so negative deltas round toward +inf.
  function automatic logic signed [WIDTH_EST-1:0] interp(
    input logic [4*WIDTH_EST-1:0] e,
    input logic [1:0]             p0,
    input logic [3:0]             n
  );
    logic [3:0]                  rel;
    logic [1:0]                  k;
    logic [1:0]                  m;
    logic signed [WIDTH_EST-1:0] a;
    logic signed [WIDTH_EST-1:0] b;
    logic signed [WIDTH_EST:0]   d;
    logic signed [c_pw-1:0]      mulc;
    logic signed [c_pw-1:0]      prod;
    rel = n - {2'b00, p0};
    k   = 2'd0;
    m   = 2'd0;
    case (rel)
      4'd1:    m = 2'd1;
      4'd2:    m = 2'd2;
      4'd3:    k = 2'd1;
      4'd4:    begin k = 2'd1; m = 2'd1; end
      4'd5:    begin k = 2'd1; m = 2'd2; end
      4'd6:    k = 2'd2;
      4'd7:    begin k = 2'd2; m = 2'd1; end
      4'd8:    begin k = 2'd2; m = 2'd2; end
      4'd9:    k = 2'd3;
      default: ;
    endcase
    a    = e[int'(k) * WIDTH_EST +: WIDTH_EST];
    b    = e[int'(k + 2'd1) * WIDTH_EST +: WIDTH_EST];
    d    = {b[WIDTH_EST-1], b} - {a[WIDTH_EST-1], a};
    mulc = (m == 2'd2) ? c_pw'(2 * DIV3_MUL) :
           (m == 2'd1) ? c_pw'(DIV3_MUL) : '0;
    prod = (c_pw'(d) * mulc + c_pw'(32768)) >>> 16;
    if (n < {2'b00, p0}) begin
      return e[WIDTH_EST-1:0];
    end else if (rel > 4'd9) begin
      return e[4*WIDTH_EST-1 -: WIDTH_EST];
    end
    return WIDTH_EST'(c_pw'(a) + prod);
  endfunction

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    valid_d = valid_q;
    capture = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          n_d     = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!valid_q || out_ready) begin
          load    = 1'b1;
          valid_d = 1'b1;
          n_d     = n_q + 4'd1;
          if (n_q == 4'd11) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= 4'd0;
      valid_q <= 1'b0;
      e_re_q  <= '0;
      e_im_q  <= '0;
      p0_q    <= 2'd0;
      h_re_q  <= '0;
      h_im_q  <= '0;
      sc_q    <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      if (capture) begin
        e_re_q <= e_re;
        e_im_q <= e_im;
        p0_q   <= (nrs_shift == 2'd3) ? 2'd2 : nrs_shift;
      end
      if (load) begin
        h_re_q <= interp(e_re_q, p0_q, n_q);
        h_im_q <= interp(e_im_q, p0_q, n_q);
        sc_q   <= n_q;
        last_q <= (n_q == 4'd11);
      end
    end
  end

  assign out_valid = valid_q;
  assign h_re      = h_re_q;
  assign h_im      = h_im_q;
  assign sc_idx    = sc_q;
  assign last      = last_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
